qspi_slave_wb_bridge: RTL and testbench

SPI/QSPI slave that converts serial command frames from an external host into single 32-bit Wishbone master transfers. It sits between the chip pads (sclk/ssn/sd[3:0]) and an on-chip Wishbone memory. Serial pins are oversampled in the sys_clk domain. Debug strobes are exported for scope triggering.

---
 rtl/qspi_slave_wb_bridge.sv | 251 +++++++++++++++++++++++++
 tb/tb_qspi_slave_wb_bridge.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qspi_slave_wb_bridge.sv
// SPI/QSPI (mode 0) slave that turns serial command frames into single 32-bit Wishbone transfers.
// Optional build macro QSPI_QUAD_EN adds quad write (8'h32) and quad read (8'h6B) opcodes.
module qspi_slave_wb_bridge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  WR_CMD      = 8'h02,
    parameter logic [7:0]  RD_CMD      = 8'h0B,
    parameter int unsigned DUMMY_CYC   = 8
) (
    input  logic        sys_clk,
    input  logic        rst_n,
    input  logic        sclk,
    input  logic        ssn,
    input  logic [3:0]  sdin,
    output logic [3:0]  sdout,
    output logic        sdout_oen,
    output logic [2:0]  spi_if_st,
    output logic        sck_toggle,
    output logic [5:0]  bitcnt,
    output logic        inst_trg,
    output logic        addr_trg,
    output logic        spi_st_trans,
    output logic        spi_trig,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic [31:0] wbm_adr_o,
    output logic        wbm_we_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i
);
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 6;
    localparam logic [7:0] QWR_CMD = 8'h32;
    localparam logic [7:0] QRD_CMD = 8'h6B;
`ifdef QSPI_QUAD_EN
    localparam logic QUAD_OK = 1'b1;
`else
    localparam logic QUAD_OK = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CMD    = 3'd1,
        S_ADDR   = 3'd2,
        S_DUMMY  = 3'd3,
        S_WDATA  = 3'd4,
        S_RDATA  = 3'd5,
        S_IGNORE = 3'd6
    } st_t;

    st_t                         state, state_d;
    logic [SYNC_STAGES-1:0]      sclk_sync, ssn_sync;
    logic [SYNC_STAGES-1:0][3:0] sdin_sync;
    logic                        sclk_d, ssn_d;
    logic [DW-1:0]               sh, addr_q, tx, rd_data;
    logic                        is_rd, quad;
    logic                        pend, pend_we;
    logic [DW-1:0]               pend_adr, pend_dat;

    logic          sclk_s, ssn_s, sclk_rise, sclk_fall, ssn_rise, ssn_fall;
    logic [3:0]    sdin_s;
    logic [DW-1:0] sh_in, tx_next;
    logic [7:0]    opcode;
    logic [CW-1:0] data_last;

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign ssn_s     = ssn_sync[SYNC_STAGES-1];
    assign sdin_s    = sdin_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign ssn_rise  = ssn_s & ~ssn_d;
    assign ssn_fall  = ~ssn_s & ssn_d;

    // Shift paths: one bit on sdin[0] or one nibble on sdin[3:0], MSB first.
    assign sh_in     = quad ? {sh[DW-5:0], sdin_s} : {sh[DW-2:0], sdin_s[0]};
    assign tx_next   = quad ? {tx[DW-5:0], 4'h0} : {tx[DW-2:0], 1'b0};
    assign opcode    = {sh[6:0], sdin_s[0]};
    assign data_last = quad ? CW'(7) : CW'(31);

    assign spi_if_st = state;
    assign wbm_sel_o = 4'hF;

    function automatic logic [3:0] out_lanes(input logic [DW-1:0] v, input logic q);
        return q ? v[DW-1:DW-4] : {2'b00, v[DW-1], 1'b0};
    endfunction

    // Pad synchronizers and edge-detect history; ssn idles high so reset cannot fake a frame start.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            ssn_sync  <= '1;
            sdin_sync <= '0;
            sclk_d    <= 1'b0;
            ssn_d     <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            ssn_sync  <= {ssn_sync[SYNC_STAGES-2:0], ssn};
            sdin_sync <= {sdin_sync[SYNC_STAGES-2:0], sdin};
            sclk_d    <= sclk_s;
            ssn_d     <= ssn_s;
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            state_d      <= S_IDLE;
            bitcnt       <= '0;
            sh           <= '0;
            addr_q       <= '0;
            tx           <= '0;
            rd_data      <= '0;
            is_rd        <= 1'b0;
            quad         <= 1'b0;
            sdout        <= '0;
            sdout_oen    <= 1'b1;
            sck_toggle   <= 1'b0;
            inst_trg     <= 1'b0;
            addr_trg     <= 1'b0;
            spi_trig     <= 1'b0;
            spi_st_trans <= 1'b0;
            pend         <= 1'b0;
            pend_we      <= 1'b0;
            pend_adr     <= '0;
            pend_dat     <= '0;
            wbm_cyc_o    <= 1'b0;
            wbm_stb_o    <= 1'b0;
            wbm_we_o     <= 1'b0;
            wbm_adr_o    <= '0;
            wbm_dat_o    <= '0;
        end else begin
            inst_trg     <= 1'b0;
            addr_trg     <= 1'b0;
            spi_trig     <= 1'b0;
            state_d      <= state;
            spi_st_trans <= (state != state_d);
            if (sclk_rise)
                sck_toggle <= ~sck_toggle;

            // Wishbone side: one transfer in flight, a queued request launches once the bus is free.
            if (wbm_cyc_o) begin
                if (wbm_ack_i || wbm_err_i) begin
                    wbm_cyc_o <= 1'b0;
                    wbm_stb_o <= 1'b0;
                    if (!wbm_we_o)
                        rd_data <= wbm_err_i ? '1 : wbm_dat_i;
                end
            end else if (pend) begin
                wbm_cyc_o <= 1'b1;
                wbm_stb_o <= 1'b1;
                wbm_we_o  <= pend_we;
                wbm_adr_o <= pend_adr;
                wbm_dat_o <= pend_dat;
                pend      <= 1'b0;
            end

            if (ssn_rise) begin
                state     <= S_IDLE;
                bitcnt    <= '0;
                sdout_oen <= 1'b1;
                sdout     <= '0;
            end else begin
                unique case (state)
                    S_IDLE: if (ssn_fall) begin
                        state    <= S_CMD;
                        bitcnt   <= '0;
                        sh       <= '0;
                        quad     <= 1'b0;
                        spi_trig <= 1'b1;
                    end
                    S_CMD: if (sclk_rise) begin
                        sh     <= sh_in;
                        bitcnt <= bitcnt + CW'(1);
                        if (bitcnt == CW'(7)) begin
                            inst_trg <= 1'b1;
                            bitcnt   <= '0;
                            if (opcode == WR_CMD || opcode == RD_CMD) begin
                                state <= S_ADDR;
                                is_rd <= (opcode == RD_CMD);
                            end else if (QUAD_OK && (opcode == QWR_CMD || opcode == QRD_CMD)) begin
                                state <= S_ADDR;
                                quad  <= 1'b1;
                                is_rd <= (opcode == QRD_CMD);
                            end else begin
                                state <= S_IGNORE;
                            end
                        end
                    end
                    S_ADDR: if (sclk_rise) begin
                        sh     <= sh_in;
                        bitcnt <= bitcnt + CW'(1);
                        if (bitcnt == data_last) begin
                            addr_trg <= 1'b1;
                            bitcnt   <= '0;
                            addr_q   <= sh_in;
                            if (is_rd) begin
                                state    <= S_DUMMY;
                                pend     <= 1'b1;
                                pend_we  <= 1'b0;
                                pend_adr <= sh_in;
                            end else begin
                                state <= S_WDATA;
                            end
                        end
                    end
                    // After the last dummy rise, the next fall drives the first read bit.
                    S_DUMMY: begin
                        if (bitcnt == CW'(DUMMY_CYC)) begin
                            if (sclk_fall) begin
                                state     <= S_RDATA;
                                bitcnt    <= '0;
                                sdout_oen <= 1'b0;
                                tx        <= rd_data;
                                sdout     <= out_lanes(rd_data, quad);
                            end
                        end else if (sclk_rise) begin
                            bitcnt <= bitcnt + CW'(1);
                        end
                    end
                    S_WDATA: if (sclk_rise) begin
                        sh     <= sh_in;
                        bitcnt <= bitcnt + CW'(1);
                        if (bitcnt == data_last) begin
                            state    <= S_IGNORE;
                            bitcnt   <= '0;
                            pend     <= 1'b1;
                            pend_we  <= 1'b1;
                            pend_adr <= addr_q;
                            pend_dat <= sh_in;
                        end
                    end
                    S_RDATA: if (sclk_fall) begin
                        if (bitcnt == data_last) begin
                            state     <= S_IGNORE;
                            bitcnt    <= '0;
                            sdout_oen <= 1'b1;
                            sdout     <= '0;
                        end else begin
                            bitcnt <= bitcnt + CW'(1);
                            tx     <= tx_next;
                            sdout  <= out_lanes(tx_next, quad);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_qspi_slave_wb_bridge.sv
// Self-checking bench: SPI host tasks, Wishbone slave memory, and a word-level reference model.
module tb_qspi_slave_wb_bridge;
    localparam int unsigned H     = 8;
    localparam int unsigned DUMMY = 8;

    logic        sys_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sclk = 1'b0;
    logic        ssn = 1'b1;
    logic [3:0]  sdin = 4'h0;
    logic [3:0]  sdout;
    logic        sdout_oen;
    logic [2:0]  spi_if_st;
    logic        sck_toggle;
    logic [5:0]  bitcnt;
    logic        inst_trg, addr_trg, spi_st_trans, spi_trig;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [31:0] wbm_adr_o, wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_dat_i = '0;
    logic        wbm_ack_i = 1'b0;
    logic        wbm_err_i = 1'b0;

    qspi_slave_wb_bridge dut (
        .sys_clk(sys_clk), .rst_n(rst_n), .sclk(sclk), .ssn(ssn), .sdin(sdin),
        .sdout(sdout), .sdout_oen(sdout_oen), .spi_if_st(spi_if_st), .sck_toggle(sck_toggle),
        .bitcnt(bitcnt), .inst_trg(inst_trg), .addr_trg(addr_trg), .spi_st_trans(spi_st_trans),
        .spi_trig(spi_trig), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_adr_o(wbm_adr_o),
        .wbm_we_o(wbm_we_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o), .wbm_dat_i(wbm_dat_i),
        .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i)
    );

    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Pulse counters
    int n_inst = 0, n_addr = 0, n_trans = 0, n_trig = 0;
    always @(posedge sys_clk) begin
        if (inst_trg)     n_inst++;
        if (addr_trg)     n_addr++;
        if (spi_st_trans) n_trans++;
        if (spi_trig)     n_trig++;
    end

    // Wishbone slave with programmable latency, error injection and ack hold-off
    int          wb_lat = 2;
    bit          wb_err = 0;
    bit          wb_hold = 0;
    int          n_cyc = 0;
    int          s_cnt = 0;
    bit          s_busy = 0, s_done = 0;
    logic [31:0] last_adr = '0, last_dat = '0;
    logic        last_we = 1'b0;
    logic [3:0]  last_sel = '0;
    logic [31:0] slv_mem [16] = '{default: '0};

    always @(posedge sys_clk) begin
        wbm_ack_i <= 1'b0;
        wbm_err_i <= 1'b0;
        if (!wbm_cyc_o) begin
            s_busy <= 0;
            s_done <= 0;
        end else if (!s_busy) begin
            s_busy   <= 1;
            s_cnt    <= wb_lat;
            n_cyc    <= n_cyc + 1;
            last_adr <= wbm_adr_o;
            last_dat <= wbm_dat_o;
            last_we  <= wbm_we_o;
            last_sel <= wbm_sel_o;
        end else if (s_cnt > 1) begin
            s_cnt <= s_cnt - 1;
        end else if (!s_done && !wb_hold) begin
            s_done <= 1;
            if (wb_err) wbm_err_i <= 1'b1;
            else begin
                wbm_ack_i <= 1'b1;
                if (wbm_we_o) slv_mem[wbm_adr_o[5:2]] <= wbm_dat_o;
                else          wbm_dat_i <= slv_mem[wbm_adr_o[5:2]];
            end
        end
    end

    // Reference model: memory image and the word the bridge would shift out next
    logic [31:0] ref_mem [16] = '{default: '0};
    logic [31:0] last_rd = '0;
    int bad_oen = 0, bad_lane = 0;
    int b_inst, b_addr, b_trans, b_cyc;

    task automatic sclk_cycle(input logic [3:0] d, output logic [3:0] q, output logic oen);
        sdin = d;
        repeat (H) @(negedge sys_clk);
        q   = sdout;
        oen = sdout_oen;
        sclk = 1'b1;
        repeat (H) @(negedge sys_clk);
        sclk = 1'b0;
    endtask

    task automatic send_bits(input logic [31:0] v, input int n, input bit quad);
        logic [3:0] q, d;
        logic       o;
        for (int i = 0; i < n; i++) begin
            d = quad ? v[4*(n-1-i) +: 4] : {3'b000, v[n-1-i]};
            sclk_cycle(d, q, o);
            if (o !== 1'b1) bad_oen++;
        end
    endtask

    task automatic recv_word(input bit quad, output logic [31:0] v);
        logic [3:0] q;
        logic       o;
        v = '0;
        for (int i = 0; i < (quad ? 8 : 32); i++) begin
            sclk_cycle(4'h0, q, o);
            if (o !== 1'b0) bad_oen++;
            if (!quad && (q & 4'b1101) != 4'b0000) bad_lane++;
            v = quad ? {v[27:0], q} : {v[30:0], q[1]};
        end
    endtask

    task automatic frame_begin();
        bad_oen = 0; bad_lane = 0;
        b_inst = n_inst; b_addr = n_addr; b_trans = n_trans; b_cyc = n_cyc;
        ssn = 1'b0;
        repeat (H) @(negedge sys_clk);
    endtask

    task automatic frame_end();
        repeat (H) @(negedge sys_clk);
        ssn = 1'b1;
        repeat (4*H) @(negedge sys_clk);
    endtask

    task automatic wait_wb_idle(input string tag);
        for (int i = 0; i < 200 && wbm_cyc_o; i++) @(negedge sys_clk);
        check_eq({tag, "_wb_idle"}, 32'(wbm_cyc_o), 32'h0);
    endtask

    task automatic common_checks(input string tag, input int inst, input int addr, input int trans);
        check_eq({tag, "_inst_trg"}, 32'(n_inst - b_inst), 32'(inst));
        check_eq({tag, "_addr_trg"}, 32'(n_addr - b_addr), 32'(addr));
        check_eq({tag, "_st_trans"}, 32'(n_trans - b_trans), 32'(trans));
        check_eq({tag, "_oen"}, 32'(bad_oen), 32'h0);
        check_eq({tag, "_state_end"}, 32'(spi_if_st), 32'h0);
        check_eq({tag, "_bitcnt_end"}, 32'(bitcnt), 32'h0);
    endtask

    task automatic wr_frame(input string tag, input logic [7:0] op, input logic [31:0] a,
                            input logic [31:0] d, input bit quad);
        frame_begin();
        send_bits(32'(op), 8, 1'b0);
        send_bits(a, quad ? 8 : 32, quad);
        send_bits(d, quad ? 8 : 32, quad);
        frame_end();
        wait_wb_idle(tag);
        check_eq({tag, "_cycles"}, 32'(n_cyc - b_cyc), 32'h1);
        check_eq({tag, "_adr"}, last_adr, a);
        check_eq({tag, "_dat"}, last_dat, d);
        check_eq({tag, "_we"}, 32'(last_we), 32'h1);
        check_eq({tag, "_sel"}, 32'(last_sel), 32'hF);
        common_checks(tag, 1, 1, 5);
        if (!wb_err) ref_mem[a[5:2]] = d;
    endtask

    task automatic rd_frame(input string tag, input logic [7:0] op, input logic [31:0] a,
                            input bit quad, input logic [31:0] exp, input bit held);
        logic [31:0] v;
        frame_begin();
        send_bits(32'(op), 8, 1'b0);
        send_bits(a, quad ? 8 : 32, quad);
        send_bits(32'h0, DUMMY, 1'b0);
        recv_word(quad, v);
        frame_end();
        check_eq({tag, "_data"}, v, exp);
        check_eq({tag, "_lanes"}, 32'(bad_lane), 32'h0);
        if (!held) wait_wb_idle(tag);
        check_eq({tag, "_cycles"}, 32'(n_cyc - b_cyc), 32'h1);
        check_eq({tag, "_adr"}, last_adr, a);
        check_eq({tag, "_we"}, 32'(last_we), 32'h0);
        common_checks(tag, 1, 1, 6);
    endtask

    task automatic ignore_frame(input string tag, input logic [7:0] op);
        frame_begin();
        send_bits(32'(op), 8, 1'b0);
        send_bits($urandom, 32, 1'b0);
        send_bits($urandom, 32, 1'b0);
        repeat (H) @(negedge sys_clk);
        check_eq({tag, "_state"}, 32'(spi_if_st), 32'h6);
        frame_end();
        check_eq({tag, "_cycles"}, 32'(n_cyc - b_cyc), 32'h0);
        common_checks(tag, 1, 0, 3);
    endtask

    initial begin
        logic [31:0] a, d, exp;
        repeat (5) @(negedge sys_clk);
        check_eq("rst_oen", 32'(sdout_oen), 32'h1);
        check_eq("rst_sel", 32'(wbm_sel_o), 32'hF);
        check_eq("rst_cyc", 32'(wbm_cyc_o), 32'h0);
        check_eq("rst_state", 32'(spi_if_st), 32'h0);
        check_eq("rst_sdout", 32'(sdout), 32'h0);
        rst_n = 1'b1;
        repeat (5) @(negedge sys_clk);

        wb_lat = 2;
        wr_frame("wr_dir", 8'h02, 32'h0000_0010, 32'hA5A5_1234, 1'b0);
        check_eq("spi_trig_cnt", 32'(n_trig - 0), 32'h1);
        exp = ref_mem[4];
        rd_frame("rd_dir", 8'h0B, 32'h0000_0010, 1'b0, exp, 1'b0);
        last_rd = exp;

        ignore_frame("bad_op", 8'h9F);

        // Write aborted after 16 data bits must never reach the bus
        frame_begin();
        send_bits(32'h02, 8, 1'b0);
        send_bits(32'h0000_0010, 32, 1'b0);
        send_bits(32'hDEAD, 16, 1'b0);
        frame_end();
        check_eq("abort_cycles", 32'(n_cyc - b_cyc), 32'h0);
        common_checks("abort", 1, 1, 4);
        rd_frame("rd_after_abort", 8'h0B, 32'h0000_0010, 1'b0, ref_mem[4], 1'b0);
        last_rd = ref_mem[4];

        // Unacknowledged read shifts out the previous read-register content
        wb_hold = 1;
        rd_frame("rd_noack", 8'h0B, 32'h0000_0020, 1'b0, last_rd, 1'b1);
        wb_hold = 0;
        wait_wb_idle("rd_noack_release");
        last_rd = ref_mem[8];

        // Reset during an unacknowledged read
        wb_hold = 1;
        frame_begin();
        send_bits(32'h0B, 8, 1'b0);
        send_bits(32'h0000_0030, 32, 1'b0);
        send_bits(32'h0, 3, 1'b0);
        check_eq("rst_mid_pre_cyc", 32'(wbm_cyc_o), 32'h1);
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_cyc", 32'(wbm_cyc_o), 32'h0);
        check_eq("rst_mid_stb", 32'(wbm_stb_o), 32'h0);
        check_eq("rst_mid_oen", 32'(sdout_oen), 32'h1);
        check_eq("rst_mid_state", 32'(spi_if_st), 32'h0);
        check_eq("rst_mid_bitcnt", 32'(bitcnt), 32'h0);
        check_eq("rst_mid_adr", wbm_adr_o, 32'h0);
        check_eq("rst_mid_sel", 32'(wbm_sel_o), 32'hF);
        check_eq("rst_mid_toggle", 32'(sck_toggle), 32'h0);
        ssn = 1'b1;
        sclk = 1'b0;
        repeat (4) @(negedge sys_clk);
        rst_n = 1'b1;
        wb_hold = 0;
        repeat (4*H) @(negedge sys_clk);
        last_rd = 32'h0;

        // Randomized single-line traffic
        for (int i = 0; i < 16; i++) begin
            a = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
            d = $urandom;
            wb_lat = $urandom_range(1, 3);
            wb_err = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 1) == 1) begin
                exp = wb_err ? 32'hFFFF_FFFF : ref_mem[a[5:2]];
                rd_frame("rnd_rd", 8'h0B, a, 1'b0, exp, 1'b0);
                last_rd = exp;
            end else begin
                wr_frame("rnd_wr", 8'h02, a, d, 1'b0);
            end
        end
        wb_err = 0;

`ifdef QSPI_QUAD_EN
        wr_frame("quad_wr", 8'h32, 32'h0000_0004, 32'h1234_5678, 1'b1);
        rd_frame("quad_rd", 8'h6B, 32'h0000_0004, 1'b1, ref_mem[1], 1'b0);
`else
        ignore_frame("quad_wr_off", 8'h32);
        ignore_frame("quad_rd_off", 8'h6B);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
